// File: rtl/overdrive_pkg.sv
// overdrive_pkg: shared state encoding, level constants and the
// soft-clip shaping function used by the datapath and its reference model.
package overdrive_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAIN,
    S_SQR,
    S_CUBE,
    S_OUT
  } od_state_t;

  localparam int SAMPLE_W = 32;

  function automatic logic signed [31:0] one_level(input int bpl);
    return 32'sd1 <<< (bpl + 1);
  endfunction

  function automatic logic signed [31:0] half_level(input int bpl);
    return one_level(bpl) >>> 1;
  endfunction

  function automatic logic od_saturates(
    input logic signed [31:0] x,
    input int                 bpl
  );
    return (x >= one_level(bpl)) || (x <= -one_level(bpl));
  endfunction

  // Hard clip at +/-ONE_LEVEL, cubic soft knee inside, plus x LSB noise.
  function automatic logic [31:0] od_shape(
    input logic signed [31:0] x,
    input logic signed [31:0] x3,
    input int                 bpl,
    input int                 nb
  );
    logic signed [33:0] w_sum;
    logic signed [31:0] w_shp;
    logic signed [31:0] w_msk;
    w_msk = (32'sd1 <<< nb) - 32'sd1;
    w_sum = {{2{x[31]}}, x} + {{2{x[31]}}, x} + {{2{x[31]}}, x}
          + {{2{x3[31]}}, x3};
    if (x >= one_level(bpl))
      w_shp = half_level(bpl);
    else if (x <= -one_level(bpl))
      w_shp = -half_level(bpl);
    else
      w_shp = w_sum[33:2];
    return w_shp + (x & w_msk);
  endfunction

endpackage

// File: rtl/overdrive_seq_fixed_multiply.sv
// fixed_multiply: signed fixed-point product, low OPERAND_SIZE bits
// of (a*b) >> FRACTIONAL_SIZE.
module fixed_multiply #(
  parameter int OPERAND_SIZE    = 32,
  parameter int FRACTIONAL_SIZE = 12
) (
  input  logic [OPERAND_SIZE-1:0] i_a,
  input  logic [OPERAND_SIZE-1:0] i_b,
  output logic [OPERAND_SIZE-1:0] o_p
);

  localparam int W = OPERAND_SIZE + FRACTIONAL_SIZE;

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W-1:0] w_full;
  logic [W-1:0] w_shr;

  // Only the bits that survive the shift are needed, so the product
  // is kept at W bits; sign extension makes the low bits signed-correct.
  assign w_a    = {{FRACTIONAL_SIZE{i_a[OPERAND_SIZE-1]}}, i_a};
  assign w_b    = {{FRACTIONAL_SIZE{i_b[OPERAND_SIZE-1]}}, i_b};
  assign w_full = w_a * w_b;
  assign w_shr  = w_full >> FRACTIONAL_SIZE;
  assign o_p    = w_shr[OPERAND_SIZE-1:0];

endmodule

// File: rtl/overdrive_seq.sv
// overdrive_seq: sequential overdrive (gain, cube soft clip, noise)
// sharing one fixed-point multiplier across GAIN/SQR/CUBE states.
module overdrive_seq
  import overdrive_pkg::*;
#(
  parameter int BITS_PER_LEVEL = 12,
  parameter int NOISE_BITS     = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_sample,
  input  logic [31:0] i_gain,
  input  logic        i_bypass,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_sample,
  output logic        o_busy
);

  od_state_t   r_state;
  od_state_t   w_nxt;
  logic [31:0] r_samp;
  logic [31:0] r_gain;
  logic        r_bypass;
  logic [31:0] r_x;
  logic [31:0] r_x2;
  logic [31:0] r_out;

  logic [31:0] w_ma;
  logic [31:0] w_mb;
  logic [31:0] w_prod;
  logic [31:0] w_res;
  logic        w_ld;
  logic        w_accept;
  logic        w_sat;

  fixed_multiply #(
    .OPERAND_SIZE    (32),
    .FRACTIONAL_SIZE (BITS_PER_LEVEL)
  ) u_mul (
    .i_a (w_ma),
    .i_b (w_mb),
    .o_p (w_prod)
  );

  assign o_ready  = (r_state == S_IDLE) && !i_rst;
  assign o_valid  = (r_state == S_OUT);
  assign o_busy   = (r_state != S_IDLE);
  assign o_sample = r_out;
  assign w_accept = i_valid && o_ready;
  assign w_sat    = od_saturates(w_prod, BITS_PER_LEVEL);

  // Next state, multiplier operand select and output-register load.
  always_comb begin
    w_nxt = r_state;
    w_ma  = '0;
    w_mb  = '0;
    w_ld  = 1'b0;
    w_res = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (i_bypass) begin
            w_nxt = S_OUT;
            w_ld  = 1'b1;
            w_res = i_sample;
          end else begin
            w_nxt = S_GAIN;
          end
        end
      end
      S_GAIN: begin
        w_ma = r_samp;
        w_mb = r_gain;
        if (w_sat) begin
          w_nxt = S_OUT;
          w_ld  = 1'b1;
          w_res = r_bypass ? r_samp :
                  od_shape(w_prod, '0, BITS_PER_LEVEL, NOISE_BITS);
        end else begin
          w_nxt = S_SQR;
        end
      end
      S_SQR: begin
        w_ma  = r_x;
        w_mb  = r_x;
        w_nxt = S_CUBE;
      end
      S_CUBE: begin
        w_ma  = r_x2;
        w_mb  = r_x;
        w_nxt = S_OUT;
        w_ld  = 1'b1;
        w_res = r_bypass ? r_samp :
                od_shape(r_x, w_prod, BITS_PER_LEVEL, NOISE_BITS);
      end
      S_OUT: begin
        if (i_ready)
          w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // State register and datapath registers; reset drops any sample in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_samp   <= '0;
      r_gain   <= '0;
      r_bypass <= 1'b0;
      r_x      <= '0;
      r_x2     <= '0;
      r_out    <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_samp   <= i_sample;
        r_gain   <= i_gain;
        r_bypass <= i_bypass;
      end
      if (r_state == S_GAIN)
        r_x <= w_prod;
      if (r_state == S_SQR)
        r_x2 <= w_prod;
      if (w_ld)
        r_out <= w_res;
    end
  end

endmodule

// File: tb/tb_overdrive_seq.sv
// tb_overdrive_seq: directed vectors with hand-computed results,
// hold/reset scenarios and a random handshake stream vs a model.
module tb_overdrive_seq;
  import overdrive_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_sample;
  logic [31:0] i_gain;
  logic        i_bypass;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_sample;
  logic        o_busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  overdrive_seq #(
    .BITS_PER_LEVEL (12),
    .NOISE_BITS     (5)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sample (i_sample),
    .i_gain   (i_gain),
    .i_bypass (i_bypass),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_sample (o_sample),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fm(input logic [31:0] a,
                                     input logic [31:0] b);
    logic signed [63:0] p;
    p = 64'($signed(a)) * 64'($signed(b));
    return p[43:12];
  endfunction

  function automatic logic [31:0] model(input logic [31:0] s,
                                        input logic [31:0] g,
                                        input logic b);
    logic [31:0] x, x2, x3;
    if (b) return s;
    x  = fm(s, g);
    x2 = fm(x, x);
    x3 = fm(x2, x);
    return od_shape(x, x3, 12, 5);
  endfunction

  task automatic run(input string tag, input logic [31:0] s,
                     input logic [31:0] g, input logic b,
                     input logic [31:0] exp, input int lat);
    int n;
    n = 0;
    while (!o_ready && n < 50) begin
      @(posedge i_clk); #1; n++;
    end
    i_valid  = 1'b1;
    i_sample = s;
    i_gain   = g;
    i_bypass = b;
    @(posedge i_clk); #1;
    i_valid  = 1'b0;
    i_sample = ~s;
    i_gain   = 32'h7fff_ffff;
    i_bypass = ~b;
    n = 1;
    while (!o_valid && n < 20) begin
      @(posedge i_clk); #1; n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_val"}, o_sample, exp);
    @(posedge i_clk); #1;
  endtask

  initial begin
    int seen;
    int sent;
    int rcv;
    int cyc;
    logic acc;
    logic [31:0] q[$];

    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_sample = '0;
    i_gain   = 32'd4096;
    i_bypass = 1'b0;
    i_ready  = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_sample", o_sample, 0);
    chk("rst_ready", o_ready, 0);
    i_rst = 1'b0;
    #1;
    chk("idle_ready", o_ready, 1);

    run("one", 32'd4096, 32'd4096, 1'b0, 32'h0000_1000, 4);
    run("sat_pos", 32'd8192, 32'd4096, 1'b0, 32'd4096, 2);
    run("sat_neg", 32'hFFFF_E000, 32'd4096, 1'b0, 32'hFFFF_F000, 2);
    run("g2", 32'd1000, 32'd8192, 1'b0, 32'd1635, 4);
    run("zero", 32'd0, 32'd4096, 1'b0, 32'd0, 4);
    run("neg", -32'sd1000, 32'd4096, 1'b0, -32'sd741, 4);
    run("knee", 32'd8191, 32'd4096, 1'b0, 32'd14363, 4);

    i_ready = 1'b0;
    run("byp", 32'h1234_5678, 32'd4096, 1'b1, 32'h1234_5678, 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", o_valid, 1);
      chk("hold_sample", o_sample, 32'h1234_5678);
      chk("hold_ready", o_ready, 0);
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("rel_valid", o_valid, 0);
    chk("rel_ready", o_ready, 1);

    i_valid  = 1'b1;
    i_sample = 32'd1000;
    i_gain   = 32'd8192;
    i_bypass = 1'b0;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("sqr_busy", o_busy, 1);
    i_rst = 1'b1;
    #1;
    chk("rst_hi_ready", o_ready, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("mid_busy", o_busy, 0);
    chk("mid_valid", o_valid, 0);
    chk("mid_sample", o_sample, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid) seen++;
      @(posedge i_clk); #1;
    end
    chk("mid_no_out", seen, 0);
    run("after_rst", 32'd4096, 32'd4096, 1'b0, 32'd4096, 4);

    sent = 0;
    rcv  = 0;
    cyc  = 0;
    i_valid  = 1'b1;
    i_sample = 32'($urandom_range(0, 16383)) - 32'd8192;
    i_gain   = ($urandom_range(0, 1) != 0) ? 32'd4096 : 32'd8192;
    i_bypass = ($urandom_range(0, 3) == 0);
    i_ready  = 1'b1;
    while (rcv < 200 && cyc < 20000) begin
      acc = 1'b0;
      if (o_valid && i_ready) begin
        if (q.size() == 0)
          chk("rnd_dup", q.size(), 1);
        else
          chk("rnd", o_sample, q.pop_front());
        rcv++;
      end
      if (i_valid && o_ready) begin
        q.push_back(model(i_sample, i_gain, i_bypass));
        sent++;
        acc = 1'b1;
      end
      @(posedge i_clk); #1;
      cyc++;
      if (acc) begin
        i_sample = 32'($urandom_range(0, 16383)) - 32'd8192;
        i_gain   = ($urandom_range(0, 1) != 0) ? 32'd4096 : 32'd8192;
        i_bypass = ($urandom_range(0, 3) == 0);
      end
      i_valid = (sent < 200);
      i_ready = ($urandom_range(0, 3) != 0);
    end
    chk("rnd_rcv", rcv, 200);
    chk("rnd_sent", sent, 200);
    chk("rnd_left", q.size(), 0);
    i_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clk); #1;
      if (o_valid) seen++;
    end
    chk("rnd_extra", seen, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
